// File: rtl/piso_stream_pkg.sv
// piso_stream_pkg: shared state type and counter-width helper for the serializer.
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} piso_state_e;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/piso_stream_if.sv
// piso_stream_if: parallel load handshake plus serial line and framing signals.
interface piso_stream_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] p_in;
  logic p_valid, p_ready, s_en, s_out, s_valid, s_first, s_last, busy;
  modport master (output p_in, p_valid, s_en, input p_ready, s_out, s_valid, s_first, s_last, busy);
  modport slave (input p_in, p_valid, s_en, output p_ready, s_out, s_valid, s_first, s_last, busy);
endinterface

// File: rtl/piso_stream_bit_counter.sv
// bit_counter: modulo-N up-counter with clear, load-to-zero, enable and terminal count.
module bit_counter import piso_pkg::*; #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  en,
  output logic [cnt_w(N)-1:0]   cnt,
  output logic                  tc
);
  assign tc = cnt == cnt_w(N)'(N - 1);
  always_ff @(posedge clk)
    if (rst || clr || load) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out serializer with load handshake and zero-gap word chaining.
module piso_stream import piso_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1,
  parameter bit IDLE_LEVEL = 0
) (
  input logic clk,
  input logic rst,
  piso_stream_if.slave bus
);
  piso_state_e state, state_nx;
  logic [DATA_WIDTH-1:0] sreg;
  logic [cnt_w(DATA_WIDTH)-1:0] cnt;
  logic tc, adv, accept, shift;
  assign shift = state == SHIFT;
  assign adv = shift && bus.s_en;
  // Ready on the last strobe of a word lets the next word follow with no idle bit.
  assign bus.p_ready = !shift || (adv && tc);
  assign accept = bus.p_valid && bus.p_ready;
  bit_counter #(.N(DATA_WIDTH)) u_cnt (
    .clk(clk), .rst(rst), .clr(adv && tc && !accept), .load(accept), .en(adv), .cnt(cnt), .tc(tc)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = accept ? SHIFT : (adv && tc) ? IDLE : state;
  always_ff @(posedge clk)
    if (rst) sreg <= '0;
    else if (accept) sreg <= bus.p_in;
    else if (adv) sreg <= MSB_FIRST ? sreg << 1 : sreg >> 1;
  always_comb begin
    bus.s_out = shift ? (MSB_FIRST ? sreg[DATA_WIDTH-1] : sreg[0]) : IDLE_LEVEL;
    bus.s_valid = shift;
    bus.busy = shift;
    bus.s_first = shift && cnt == '0;
    bus.s_last = shift && tc;
  end
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: three serializer configurations checked against a word/bit-index reference model.
module tb_piso_stream;
  logic clk, rst, en, armed;
  logic pv[3];
  logic [63:0] pin[3];
  logic [5:0] o[3];
  int checks = 0, errors = 0;
  int W[3] = '{8, 8, 2};
  bit MS[3] = '{1, 0, 1};
  bit IL[3] = '{0, 1, 0};
  logic [63:0] mem[3][1024];
  int hd[3] = '{0, 0, 0}, tl[3] = '{0, 0, 0};
  bit mb[3] = '{0, 0, 0};
  logic [63:0] mw[3];
  int mi[3];
  bit er[3], acc[3];

  piso_stream_if #(.DATA_WIDTH(8)) b0 ();
  piso_stream_if #(.DATA_WIDTH(8)) b1 ();
  piso_stream_if #(.DATA_WIDTH(2)) b2 ();
  piso_stream #(.DATA_WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  piso_stream #(.DATA_WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  piso_stream #(.DATA_WIDTH(2), .MSB_FIRST(1), .IDLE_LEVEL(0)) u2 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.p_valid = pv[0];
  assign b1.p_valid = pv[1];
  assign b2.p_valid = pv[2];
  assign b0.p_in = pin[0][7:0];
  assign b1.p_in = pin[1][7:0];
  assign b2.p_in = pin[2][1:0];
  assign b0.s_en = en;
  assign b1.s_en = en;
  assign b2.s_en = en;
  assign o[0] = {b0.p_ready, b0.s_valid, b0.s_out, b0.s_first, b0.s_last, b0.busy};
  assign o[1] = {b1.p_ready, b1.s_valid, b1.s_out, b1.s_first, b1.s_last, b1.busy};
  assign o[2] = {b2.p_ready, b2.s_valid, b2.s_out, b2.s_first, b2.s_last, b2.busy};

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%b expected=%b t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [63:0] w);
    for (int k = 0; k < 3; k++) begin
      mem[k][tl[k]] = w;
      tl[k] = tl[k] + 1;
    end
  endtask

  task automatic step(input bit r, input bit e);
    @(negedge clk);
    rst = r;
    en = e;
    for (int k = 0; k < 3; k++) begin
      pv[k] = hd[k] < tl[k];
      pin[k] = pv[k] ? mem[k][hd[k]] : {$urandom, $urandom};
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      er[k] = !mb[k] || (e && mi[k] == W[k] - 1);
      if (armed) chk("p_ready", k, o[k][5], er[k]);
      acc[k] = !r && pv[k] && er[k];
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (r) mb[k] = 0;
      else if (acc[k]) begin
        mw[k] = pin[k] & ((64'd1 << W[k]) - 64'd1);
        mi[k] = 0;
        mb[k] = 1;
        hd[k] = hd[k] + 1;
      end else if (mb[k] && e) begin
        if (mi[k] == W[k] - 1) mb[k] = 0;
        else mi[k] = mi[k] + 1;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("s_valid", k, o[k][4], mb[k]);
      chk("s_out", k, o[k][3], mb[k] ? (MS[k] ? mw[k][W[k]-1-mi[k]] : mw[k][mi[k]]) : IL[k]);
      chk("s_first", k, o[k][2], mb[k] && mi[k] == 0);
      chk("s_last", k, o[k][1], mb[k] && mi[k] == W[k] - 1);
      chk("busy", k, o[k][0], mb[k]);
    end
    armed = 1;
  endtask

  initial begin
    armed = 0;
    rst = 1;
    en = 0;
    for (int k = 0; k < 3; k++) begin
      pv[k] = 0;
      pin[k] = '0;
    end
    step(1, 0);
    step(1, 1);
    push(64'hA5);
    for (int i = 0; i < 10; i++) step(0, 1);
    push(64'hFF);
    push(64'h00);
    for (int i = 0; i < 19; i++) step(0, 1);
    push(64'h81);
    for (int i = 0; i < 40; i++) step(0, i % 4 == 0);
    push(64'hF0);
    for (int i = 0; i < 3; i++) step(0, 1);
    step(1, 1);
    for (int i = 0; i < 3; i++) step(0, 1);
    for (int i = 0; i < 4; i++) begin
      push(64'h2);
      push(64'h1);
    end
    for (int i = 0; i < 20; i++) step(0, 1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(2) == 0 && tl[0] - hd[0] < 4) push({$urandom, $urandom});
      step($urandom_range(96) == 0, $urandom_range(3) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order, a bit-rate enable strobe and zero-gap back-to-back words. It sits between a parallel word producer (FIFO or register file) and a serial line driver, replacing the fixed 4-bit free-running shifter. Framing outputs (`s_valid`, `s_first`, `s_last`) let downstream logic mark word boundaries without counting bits.

## Interface
- `DATA_WIDTH`, 8, word width in bits; legal range 2..64.
- `MSB_FIRST`, 1, 1 = bit `DATA_WIDTH-1` shifted out first, 0 = bit 0 first.
- `IDLE_LEVEL`, 0, value driven on `s_out` while no word is in flight.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p_in`  in  DATA_WIDTH  parallel word; sampled only on an accept.
- `p_valid`  in  1  producer has a word on `p_in`.
- `p_ready`  out  1  serializer accepts `p_in` this cycle.
- `s_en`  in  1  bit-period strobe; the current bit advances only on edges where `s_en`=1. Tie high for one bit per clock.
- `s_out`  out  1  serial data.
- `s_valid`  out  1  `s_out` carries a data bit.
- `s_first`  out  1  current bit is the first bit of a word.
- `s_last`  out  1  current bit is the last bit of a word.
- `busy`  out  1  word in flight (equal to `s_valid`).

## Operation
- States: IDLE, SHIFT. Shift register `sreg` is DATA_WIDTH bits. Bit counter `cnt` is `$clog2(DATA_WIDTH)` bits and counts 0..DATA_WIDTH-1.
- Accept: `p_valid && p_ready` at an edge. On accept, `sreg <= p_in`, `cnt <= 0` and state goes to SHIFT.
- `p_ready` = (state==IDLE) || (state==SHIFT && s_en && cnt==DATA_WIDTH-1). This is the only combinational input-to-output path.
- IDLE outputs: `s_out`=IDLE_LEVEL, and `s_valid`/`s_first`/`s_last`/`busy` are all 0.
- SHIFT outputs:
  - `s_out` = `sreg[DATA_WIDTH-1]` if MSB_FIRST, else `sreg[0]`.
  - `s_valid`=`busy`=1.
  - `s_first` = (cnt==0); `s_last` = (cnt==DATA_WIDTH-1).
- SHIFT with `s_en`=0: hold all state, so the bit is held.
- SHIFT with `s_en`=1 and cnt<DATA_WIDTH-1: shift toward the output end, filling the vacated end with 0, and `cnt++`.
- SHIFT with `s_en`=1 and cnt==DATA_WIDTH-1:
  - If `p_valid`=1, accept the new word and stay in SHIFT with no idle bit.
  - Otherwise go to IDLE.
- `p_in` changes while not accepting have no effect. Words are never dropped or partially overwritten.
- Reset (including mid-word): state=IDLE, `sreg`=0, `cnt`=0. The in-flight word is discarded, and outputs take IDLE values on the cycle after the reset edge.
- `rst` has priority over accept and over `s_en`.

## Timing
- Word accepted at edge N: first bit is on `s_out` with `s_first`=1 from edge N to N+1. With `s_en` tied high, this is a one-cycle load-to-first-bit latency.
- Each bit is held from one `s_en` edge to the next. A word occupies exactly DATA_WIDTH `s_en` strobes.
- Back-to-back: the last bit of word k is followed directly by the first bit of word k+1. Throughput is one word per DATA_WIDTH strobes.
- `s_en` asserted in IDLE has no effect. Accepting in IDLE does not require `s_en`.
- All outputs except `p_ready` are functions of registers only.

## Structure
- Package `piso_pkg`:
  - state enum `piso_state_e` {IDLE, SHIFT};
  - function `cnt_w(width)` returning `$clog2(width)`.
- One natural sub-module, `bit_counter`. It is a parametrised modulo-N up-counter with synchronous clear, load-to-zero and enable inputs and a terminal-count output; `s_last` and the `p_ready` term derive from its terminal-count output.
- The top module holds the FSM, `sreg` and the output mux.

## Test plan
- Reset, then DATA_WIDTH=8, MSB_FIRST=1, `s_en`=1; accept 0xA5 → `s_out` = 1,0,1,0,0,1,0,1. `s_first` is high on bit 1 and `s_last` on bit 8. Back to IDLE with `s_out`=0 after 8 cycles.
- MSB_FIRST=0, accept 0xA5 → `s_out` = 1,0,1,0,0,1,0,1 read LSB-first (bits 0..7). `p_ready`=0 for cycles 1..7 of the word.
- `p_valid` held high with words 0xFF then 0x00 → 16 contiguous valid bits, eight 1s then eight 0s. `p_ready` pulses on the 8th bit and there is no gap.
- `s_en` asserted one cycle in four, accepting 0x81 → each bit held 4 clocks and total word time is 32 clocks. `s_out` is 1 for the first and last 4-clock windows.
- Assert `rst` during bit 3 of 0xF0 → the next cycle is IDLE: `s_valid`=0, `s_out`=IDLE_LEVEL, `p_ready`=1, and the remaining bits are never emitted.
- DATA_WIDTH=2, `p_valid` constantly high with alternating 2'b10/2'b01 → `s_out` = 1,0,0,1 repeating. `s_first` and `s_last` alternate every cycle.
